// File: rtl/reg_issue_scoreboard.sv
// Decode-to-execute register issue stage with a busy-bit scoreboard.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data to sources.
module reg_issue_scoreboard #(
  parameter int DATA_WIDTH = 20,
  parameter int REG_NUMBER = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_NUMBER-1:0] dec_rs1,
  input  logic [REG_NUMBER-1:0] dec_rs2,
  input  logic [REG_NUMBER-1:0] dec_rd,
  input  logic                  dec_we,
  input  logic                  wb_valid,
  input  logic [REG_NUMBER-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_NUMBER-1:0] rf_rs1,
  output logic [REG_NUMBER-1:0] rf_rs2,
  input  logic [DATA_WIDTH-1:0] rf_data_rs1,
  input  logic [DATA_WIDTH-1:0] rf_data_rs2,
  output logic [REG_NUMBER-1:0] rf_rd,
  output logic                  rf_reg_write,
  output logic [DATA_WIDTH-1:0] rf_data_rd,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [REG_NUMBER-1:0] ex_rd,
  output logic                  ex_we,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int NREG = 2 ** REG_NUMBER;

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  wb_hit;
  logic                  raw1;
  logic                  raw2;
  logic                  waw;
  logic                  ex_free;
  logic                  issue;
  logic                  stall;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;

  assign rf_rs1       = dec_rs1;
  assign rf_rs2       = dec_rs2;
  assign rf_rd        = wb_rd;
  assign rf_data_rd   = wb_data;
  assign wb_hit       = wb_valid && (wb_rd != '0);
  assign rf_reg_write = wb_hit;

`ifdef WB_BYPASS_EN
  logic byp1;
  logic byp2;

  // The register file only commits on the edge, so take the value off the wb bus.
  assign byp1 = wb_hit && (wb_rd == dec_rs1);
  assign byp2 = wb_hit && (wb_rd == dec_rs2);
  assign raw1 = busy[dec_rs1] && !byp1;
  assign raw2 = busy[dec_rs2] && !byp2;
  assign src1 = byp1 ? wb_data : rf_data_rs1;
  assign src2 = byp2 ? wb_data : rf_data_rs2;
`else
  assign raw1 = busy[dec_rs1];
  assign raw2 = busy[dec_rs2];
  assign src1 = rf_data_rs1;
  assign src2 = rf_data_rs2;
`endif

  assign waw       = dec_we && busy[dec_rd];
  assign ex_free   = !ex_valid || ex_ready;
  assign dec_ready = !raw1 && !raw2 && !waw && ex_free;
  assign issue     = dec_valid && dec_ready;
  assign stall     = dec_valid && !dec_ready;

  // Clear from writeback first so a same-edge issue to that register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (issue && dec_we) begin
      busy_nxt[dec_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_we       <= 1'b0;
    end else if (issue) begin
      ex_valid    <= 1'b1;
      ex_rs1_data <= src1;
      ex_rs2_data <= src2;
      ex_rd       <= dec_rd;
      ex_we       <= dec_we;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_issue_scoreboard.sv
// Directed bench for reg_issue_scoreboard with a behavioural register file.
module tb_reg_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [19:0] wb_data;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [19:0] rf_data_rs1, rf_data_rs2;
  logic        rf_reg_write;
  logic [19:0] rf_data_rd;
  logic        ex_valid;
  logic        ex_ready;
  logic [19:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef WB_BYPASS_EN
  localparam int CB = 2;
`else
  localparam int CB = 3;
`endif

  always #5 clk = ~clk;

  reg_issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_we(dec_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
    .rf_rd(rf_rd), .rf_reg_write(rf_reg_write),
    .rf_data_rd(rf_data_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_we(ex_we),
    .stall_cnt(stall_cnt)
  );

  // Register file environment: x0 reads zero, xN starts at 0x100+N.
  logic [19:0] regs [32];
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 20'h0 : 20'(32'h100 + i);
  end
  always @(posedge clk) if (rf_reg_write) regs[rf_rd] <= rf_data_rd;
  assign rf_data_rs1 = regs[rf_rs1];
  assign rf_data_rs2 = regs[rf_rs2];

  typedef struct {
    string       name;
    logic        dv;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic        wv;
    logic [4:0]  wrd;
    logic [19:0] wd;
    logic        exr;
    logic        e_dready;
    logic        e_rfw;
    logic        e_exv;
    logic [19:0] e_d1, e_d2;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string n, int dv, int rs1, int rs2, int rd, int we,
                     int wv, int wrd, int wd, int exr,
                     int edr, int erfw, int eexv, int ed1, int ed2,
                     int erd, int ewe, int ecnt);
    vec_t v;
    v.name = n; v.dv = 1'(dv);
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.we = 1'(we);
    v.wv = 1'(wv); v.wrd = 5'(wrd); v.wd = 20'(wd); v.exr = 1'(exr);
    v.e_dready = 1'(edr); v.e_rfw = 1'(erfw); v.e_exv = 1'(eexv);
    v.e_d1 = 20'(ed1); v.e_d2 = 20'(ed2);
    v.e_rd = 5'(erd); v.e_we = 1'(ewe); v.e_cnt = 16'(ecnt);
    vecs.push_back(v);
  endtask

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    dec_valid = v.dv; dec_rs1 = v.rs1; dec_rs2 = v.rs2;
    dec_rd = v.rd; dec_we = v.we;
    wb_valid = v.wv; wb_rd = v.wrd; wb_data = v.wd;
    ex_ready = v.exr;
  endtask

  initial begin
    vec_t idle;
    idle = '{name: "idle", default: '0};
    drive(idle);
    rst = 1'b1;

    add("basic",    1,3,2,1,0, 0,0,0,     1, 1,0, 1,'h103,'h102,1,0,0);
    add("set_rd4",  1,1,6,4,1, 0,0,0,     1, 1,0, 1,'h101,'h106,4,1,0);
    add("raw_a",    1,4,0,2,1, 0,0,0,     1, 0,0, 0,'h101,'h106,4,1,1);
    add("raw_b",    1,4,0,2,1, 0,0,0,     1, 0,0, 0,'h101,'h106,4,1,2);
`ifdef WB_BYPASS_EN
    add("wb_byp",   1,4,0,2,1, 1,4,'h3B,  1, 1,1, 1,'h3B,0,2,1,2);
    add("byp_idle", 0,0,0,0,0, 0,0,0,     1, 1,0, 0,'h3B,0,2,1,2);
`else
    add("wb_stall", 1,4,0,2,1, 1,4,'h3B,  1, 0,1, 0,'h101,'h106,4,1,3);
    add("raw_iss",  1,4,0,2,1, 0,0,0,     1, 1,0, 1,'h3B,0,2,1,3);
`endif
    add("idle",     0,0,0,0,0, 0,0,0,     1, 1,0, 0,'h3B,0,2,1,CB);
    add("x0_dest",  1,5,7,0,1, 1,2,'h55,  1, 1,1, 1,'h105,'h107,0,1,CB);
    add("x0_src",   1,0,2,3,0, 1,0,'h77,  1, 1,0, 1,0,'h55,3,0,CB);
    add("bp_1",     1,1,1,6,1, 0,0,0,     0, 0,0, 1,0,'h55,3,0,CB+1);
    add("bp_2",     1,1,1,6,1, 0,0,0,     0, 0,0, 1,0,'h55,3,0,CB+2);
    add("bp_3",     1,1,1,6,1, 0,0,0,     0, 0,0, 1,0,'h55,3,0,CB+3);
    add("bp_go",    1,1,1,6,1, 0,0,0,     1, 1,0, 1,'h101,'h101,6,1,CB+3);
    add("same_edge",1,3,3,5,1, 1,5,'h99,  1, 1,1, 1,'h103,'h103,5,1,CB+3);
    add("raw_x5",   1,0,5,0,0, 0,0,0,     1, 0,0, 0,'h103,'h103,5,1,CB+4);
    add("waw_x6",   1,0,0,6,1, 0,0,0,     1, 0,0, 0,'h103,'h103,5,1,CB+5);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_exv", int'(ex_valid), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_exv", int'(ex_valid), 0);
    chk("post_rst_rdy", int'(dec_ready), 1);
    chk("post_rst_exrd", int'(ex_rd), 0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk({vecs[i].name, ".dec_ready"}, int'(dec_ready), int'(vecs[i].e_dready));
      chk({vecs[i].name, ".rf_we"}, int'(rf_reg_write), int'(vecs[i].e_rfw));
      @(posedge clk); #1;
      chk({vecs[i].name, ".ex_valid"}, int'(ex_valid), int'(vecs[i].e_exv));
      chk({vecs[i].name, ".rs1_data"}, int'(ex_rs1_data), int'(vecs[i].e_d1));
      chk({vecs[i].name, ".rs2_data"}, int'(ex_rs2_data), int'(vecs[i].e_d2));
      chk({vecs[i].name, ".ex_rd"}, int'(ex_rd), int'(vecs[i].e_rd));
      chk({vecs[i].name, ".ex_we"}, int'(ex_we), int'(vecs[i].e_we));
      chk({vecs[i].name, ".stall_cnt"}, int'(stall_cnt), int'(vecs[i].e_cnt));
    end

    // Mid-operation reset with x7 in flight and a held bundle.
    drive(idle);
    dec_valid = 1'b1; dec_rd = 5'd7; dec_we = 1'b1; ex_ready = 1'b0;
    #1;
    chk("r7.dec_ready", int'(dec_ready), 1);
    @(posedge clk); #1;
    dec_valid = 1'b0; dec_we = 1'b0;
    @(posedge clk); #1;
    chk("r7.held", int'(ex_valid), 1);
    chk("r7.rd", int'(ex_rd), 7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_exv", int'(ex_valid), 0);
    chk("async_cnt", int'(stall_cnt), 0);
    chk("async_exrd", int'(ex_rd), 0);
    @(posedge clk); #3;
    rst = 1'b0;
    dec_valid = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd0;
    dec_rd = 5'd0; dec_we = 1'b0; ex_ready = 1'b1;
    #1;
    chk("x7_free.rdy", int'(dec_ready), 1);
    @(posedge clk); #1;
    chk("x7_free.exv", int'(ex_valid), 1);
    chk("x7_free.d1", int'(ex_rs1_data), 'h107);
    chk("x7_free.cnt", int'(stall_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
